reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Shares one 16-bit single-port storage register between two requesters (e.g. fetch-side and execute-side units of the processor).
- The register it controls has these semantics:
  - `read_write`=1 stores `write_port1` at posedge.
  - `read_write`=0 copies stored data to `read_port1` at posedge.
- This block serialises the requests, drives the register's control and data, and returns read data/acks through a valid/ready request and pulsed-response handshake.

Parameters:
- `WIDTH`, 16, data width of register and request/response data.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous reset, active-high.
- `req0_valid` input 1: requester 0 has a pending operation.
- `req0_rw` input 1: requester 0 operation type; 1=write, 0=read.
- `req0_wdata` input `WIDTH`: requester 0 write data.
- `req0_ready` output 1: requester 0 operation accepted this cycle when high with `req0_valid`.
- `rsp0_valid` output 1: one-cycle completion pulse for requester 0.
- `rsp0_rdata` output `WIDTH`: requester 0 read result; holds until next read completion.
- `req1_valid`, `req1_rw`, `req1_wdata`, `req1_ready`, `rsp1_valid`, `rsp1_rdata`: same as above for requester 1.
- `reg_rw` output 1: drives register `read_write`.
- `reg_wdata` output `WIDTH`: drives register `write_port1`.
- `reg_rdata` input `WIDTH`: from register `read_port1`.
- `busy` output 1: high when state != IDLE.

Behaviour:
- States: IDLE, WR, RD_ISSUE, RD_CAPTURE.
- Reset (`rst`=1 at posedge): state=IDLE; `rsp0_valid`=`rsp1_valid`=0; `rsp0_rdata`=`rsp1_rdata`=0; owner=0; latched wdata=0; RR pointer `last_grant`=1.
  - Any in-flight operation is abandoned with no response.
  - `reg_rw` is forced 0 while `rst`=1, so no write reaches the register during reset.
- `reg_rw`/`reg_wdata` are a combinational decode of state:
  - `reg_rw`=1 only in WR (and `rst`=0).
  - `reg_wdata`=latched wdata in all states.
  - In IDLE/RD_ISSUE/RD_CAPTURE `reg_rw`=0.
- Ready:
  - `reqN_ready` = (state==IDLE) && (grant==N) && `reqN_valid` && !`rst`, combinational.
  - Never high outside IDLE.
  - Requesters hold valid/rw/wdata stable until accepted; a valid that drops before ready is ignored.
- Arbitration (IDLE only):
  - Only one valid: it wins.
  - Both valid: winner per arbitration mode (see Optional Feature).
  - Neither valid: stay IDLE.
- Accept edge E0: latch owner, rw, wdata; next state = WR if rw=1, else RD_ISSUE.
- Write: WR lasts one cycle; register stores data at E1.
  - At E1: state→IDLE and `rspN_valid` (owner) set.
  - `rspN_valid` is high for the cycle after E1, with `rspN_rdata` unchanged.
  - Latency: accept edge to `rsp_valid` high = 1 cycle.
- Read:
  - RD_ISSUE lasts one cycle with `reg_rw`=0; register updates `read_port1` at E1.
  - RD_CAPTURE: `reg_rdata` is valid. At E2, `rspN_rdata` <= `reg_rdata`, `rspN_valid` set, state→IDLE.
  - Latency: 2 cycles.
- Response pulses:
  - `rsp_valid` is exactly one cycle and is cleared at the next edge.
  - A new accept may occur in the same cycle a `rsp_valid` is high (back-to-back).
- Ordering:
  - A read accepted after a write completes returns the written value.
  - A read before any write returns 0 (register powers up 0).
- The non-owner's `rsp_valid` stays 0 and its `rsp_rdata` holds.
- Throughput: one write per 2 cycles, one read per 3 cycles (including the IDLE cycle).

Optional Feature:
- Macro `REG_ARB_RR_EN`.
- Defined: round-robin. On contention, grant the requester != `last_grant`. `last_grant` updates to the owner on every accept (including uncontended). After reset, requester 0 wins the first contention.
- Undefined: fixed priority. On contention requester 0 always wins; `last_grant` is unused. Requester 1 may starve; this is accepted.

Test Plan:
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles; all valids 0.
  - Required: `busy`=0, `reg_rw`=0, rsp_valids 0, rsp_rdatas 0; no ready asserted.
- Single write then read, req0:
  - Stimulus: write 16'hA5A5, then read.
  - Required: write ack 1 cycle after accept. `rsp0_rdata`=16'hA5A5 with `rsp0_valid` 2 cycles after read accept. `reg_rw` high exactly 1 cycle.
- Read before any write, req1:
  - Required: `rsp1_valid` pulse with `rsp1_rdata`=16'h0000.
- Contention, both valid writing 16'h1111 / 16'h2222, repeated 4 times:
  - `REG_ARB_RR_EN` defined: grants alternate 0,1,0,1.
  - Undefined with req0 held valid: req1 never granted.
  - In both modes, the final register contents match the last granted write.
- Reset mid-operation:
  - Stimulus: assert `rst` during RD_ISSUE, and separately during WR.
  - Required: no `rsp_valid`; `reg_rw`=0 during reset. A subsequent read returns the prior stored value, not the aborted write data.
- Back-to-back:
  - Stimulus: req0 write 16'h00FF; req1 valid read waiting.
  - Required: req1 accepted in the cycle `rsp0_valid` is high. `rsp1_rdata`=16'h00FF two cycles later.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Serialises read/write requests from two requesters onto one shared
//   single-port WIDTH-bit storage register and returns pulsed responses.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     reqN_valid/rw/wdata       request from requester N (rw: 1=write, 0=read)
//     reqN_ready                request accepted this cycle (valid && ready)
//     rspN_valid                one-cycle completion pulse for requester N
//     rspN_rdata                last read result for requester N (held)
//     reg_rw, reg_wdata         control/data to the storage register
//     reg_rdata                 read port of the storage register
//     busy                      an operation is in flight
//
//   Build option:
//     REG_ARB_RR_EN  defined   -> round-robin on contention
//                    undefined -> fixed priority, requester 0 wins
module reg_access_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_rw,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_rdata,
  input  logic             req1_valid,
  input  logic             req1_rw,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_rdata,
  output logic             reg_rw,
  output logic [WIDTH-1:0] reg_wdata,
  input  logic [WIDTH-1:0] reg_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR         = 2'd1,
    RD_ISSUE   = 2'd2,
    RD_CAPTURE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
`ifdef REG_ARB_RR_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic grant;
  logic accept;
  logic sel_rw;

  // Winner among the current requests; only meaningful together with a valid.
  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef REG_ARB_RR_EN
      grant = ~last_grant_q;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = ~req0_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && !grant && req0_valid && !rst;
  assign req1_ready = (state_q == IDLE) &&  grant && req1_valid && !rst;
  assign accept     = req0_ready || req1_ready;
  assign sel_rw     = grant ? req1_rw : req0_rw;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wdata_d      = wdata_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
`ifdef REG_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          wdata_d = grant ? req1_wdata : req0_wdata;
          state_d = sel_rw ? WR : RD_ISSUE;
`ifdef REG_ARB_RR_EN
          last_grant_d = grant;
`endif
        end
      end
      WR: begin
        state_d = IDLE;
        if (owner_q) rsp1_valid_d = 1'b1;
        else         rsp0_valid_d = 1'b1;
      end
      RD_ISSUE: begin
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // Register updated its read port at the end of RD_ISSUE.
        state_d = IDLE;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_rdata_d = reg_rdata;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_rdata_d = reg_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      wdata_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
`ifdef REG_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wdata_q      <= wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
`ifdef REG_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Reset gates the write strobe so an interrupted WR never reaches storage.
  assign reg_rw     = (state_q == WR) && !rst;
  assign reg_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Testbench for reg_access_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and register.
module tb_reg_access_arbiter;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req0_rw = 1'b0;
  logic [WIDTH-1:0] req0_wdata = '0;
  logic             req1_valid = 1'b0, req1_rw = 1'b0;
  logic [WIDTH-1:0] req1_wdata = '0;
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;
  logic             reg_rw, busy;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata = '0;
  logic [WIDTH-1:0] store = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .reg_rw(reg_rw), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Shared single-port storage register (powers up 0, not reset).
  always @(posedge clk) begin
    if (reg_rw) store <= reg_wdata;
    else        reg_rdata <= store;
  end

  // Transaction model: remaining busy cycles, the in-flight op, memory image.
  int               m_rem = 0;
  logic             m_who = 1'b0, m_rw = 1'b0, m_last = 1'b1;
  logic [WIDTH-1:0] m_data = '0, m_mem = '0;
  logic [WIDTH-1:0] m_rdata [2] = '{'0, '0};
  logic [1:0]       m_rspv = '0;

  function automatic logic m_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef REG_ARB_RR_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return !v0;
  endfunction

  function automatic logic exp_ready(input int n);
    logic w;
    w = m_winner(req0_valid, req1_valid);
    if (rst || m_rem != 0) return 1'b0;
    if (n == 0) return req0_valid && !w;
    return req1_valid && w;
  endfunction

  task automatic model_tick();
    logic w;
    if (rst) begin
      m_rem = 0; m_rspv = '0; m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1'b1;
    end else begin
      m_rspv = '0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_rw) m_mem = m_data;
          else      m_rdata[m_who] = m_mem;
          m_rspv[m_who] = 1'b1;
        end
      end else if (req0_valid || req1_valid) begin
        w      = m_winner(req0_valid, req1_valid);
        m_who  = w;
        m_rw   = w ? req1_rw : req0_rw;
        m_data = w ? req1_wdata : req0_wdata;
        m_rem  = m_rw ? 1 : 2;
        m_last = w;
      end
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    req0_valid = 1'b1; req0_rw = 1'b1; req1_valid = 1'b1; req1_rw = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready got %b exp 00", {req0_ready, req1_ready}); else n_pass++;
    n_checks++; if (reg_rw !== 1'b0) $display("FAIL rst_reg_rw got %b exp 0", reg_rw); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_rw = 1'b0; req1_rw = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if ({busy, reg_rw, rsp0_valid, rsp1_valid} !== 4'b0000) $display("FAIL idle_flags got %b exp 0000", {busy, reg_rw, rsp0_valid, rsp1_valid}); else n_pass++;
    n_checks++; if (rsp0_rdata !== 16'h0000) $display("FAIL idle_rdata0 got %h exp 0000", rsp0_rdata); else n_pass++;
    n_checks++; if (rsp1_rdata !== 16'h0000) $display("FAIL idle_rdata1 got %h exp 0000", rsp1_rdata); else n_pass++;
  endtask

  task automatic test_read_before_write();
    req1_valid = 1'b1; req1_rw = 1'b0;
    #1;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL rbw_ready1 got %b exp 1", req1_ready); else n_pass++;
    tick();
    req1_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL rbw_busy got %b exp 1", busy); else n_pass++;
    tick();
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL rbw_early got %b exp 0", rsp1_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) $display("FAIL rbw_rspv got %b exp 01", {rsp0_valid, rsp1_valid}); else n_pass++;
    n_checks++; if (rsp1_rdata !== 16'h0000) $display("FAIL rbw_rdata got %h exp 0000", rsp1_rdata); else n_pass++;
    tick();
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL rbw_pulse got %b exp 0", rsp1_valid); else n_pass++;
  endtask

  task automatic test_write_read();
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 16'hA5A5;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL wr_ready got %b exp 1", req0_ready); else n_pass++;
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({reg_rw, reg_wdata} !== {1'b1, 16'hA5A5}) $display("FAIL wr_drive got %b/%h exp 1/a5a5", reg_rw, reg_wdata); else n_pass++;
    tick();
    n_checks++; if ({rsp0_valid, reg_rw, busy} !== 3'b100) $display("FAIL wr_ack got %b exp 100", {rsp0_valid, reg_rw, busy}); else n_pass++;
    n_checks++; if (rsp0_rdata !== 16'h0000) $display("FAIL wr_rdata_hold got %h exp 0000", rsp0_rdata); else n_pass++;
    req0_valid = 1'b1; req0_rw = 1'b0;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL rd_ready got %b exp 1", req0_ready); else n_pass++;
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({reg_rw, rsp0_valid} !== 2'b00) $display("FAIL rd_issue got %b exp 00", {reg_rw, rsp0_valid}); else n_pass++;
    tick();
    n_checks++; if ({reg_rw, rsp0_valid} !== 2'b00) $display("FAIL rd_capture got %b exp 00", {reg_rw, rsp0_valid}); else n_pass++;
    tick();
    n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b1, 16'hA5A5}) $display("FAIL rd_rsp got %b/%h exp 1/a5a5", rsp0_valid, rsp0_rdata); else n_pass++;
    tick();
    n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b0, 16'hA5A5}) $display("FAIL rd_hold got %b/%h exp 0/a5a5", rsp0_valid, rsp0_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0]       exp_seq;
    logic [WIDTH-1:0] last_data;
    logic             g;
`ifdef REG_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    last_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 16'h1111;
    req1_valid = 1'b1; req1_rw = 1'b1; req1_wdata = 16'h2222;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = exp_seq[i];
      last_data = g ? 16'h2222 : 16'h1111;
      n_checks++; if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) $display("FAIL cont_grant%0d got %b exp %b", i, {req0_ready, req1_ready}, g ? 2'b01 : 2'b10); else n_pass++;
      tick();
      n_checks++; if ({req0_ready, req1_ready, reg_rw} !== 3'b001) $display("FAIL cont_wr%0d got %b exp 001", i, {req0_ready, req1_ready, reg_rw}); else n_pass++;
      tick();
      n_checks++; if ({rsp0_valid, rsp1_valid} !== (g ? 2'b01 : 2'b10)) $display("FAIL cont_rsp%0d got %b exp %b", i, {rsp0_valid, rsp1_valid}, g ? 2'b01 : 2'b10); else n_pass++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (store !== last_data) $display("FAIL cont_store got %h exp %h", store, last_data); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 16'h3C3C;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_rw = 1'b0;
    tick();
    req1_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (reg_rw !== 1'b0) $display("FAIL rdrst_reg_rw got %b exp 0", reg_rw); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if ({rsp1_valid, busy} !== 2'b00) $display("FAIL rdrst_after got %b exp 00", {rsp1_valid, busy}); else n_pass++;
    tick();
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL rdrst_norsp got %b exp 0", rsp1_valid); else n_pass++;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 16'hDEAD;
    tick();
    req0_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (reg_rw !== 1'b0) $display("FAIL wrrst_reg_rw got %b exp 0", reg_rw); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b0, 16'h0000}) $display("FAIL wrrst_after got %b/%h exp 0/0000", rsp0_valid, rsp0_rdata); else n_pass++;
    tick();
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL wrrst_norsp got %b exp 0", rsp0_valid); else n_pass++;
    n_checks++; if (store !== 16'h3C3C) $display("FAIL wrrst_store got %h exp 3c3c", store); else n_pass++;
    req0_valid = 1'b1; req0_rw = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b1, 16'h3C3C}) $display("FAIL wrrst_read got %b/%h exp 1/3c3c", rsp0_valid, rsp0_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 16'h00FF;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_rw = 1'b0;
    #1;
    n_checks++; if (req1_ready !== 1'b0) $display("FAIL b2b_wait got %b exp 0", req1_ready); else n_pass++;
    tick();
    n_checks++; if ({rsp0_valid, req1_ready} !== 2'b11) $display("FAIL b2b_accept got %b exp 11", {rsp0_valid, req1_ready}); else n_pass++;
    tick();
    req1_valid = 1'b0;
    tick();
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL b2b_early got %b exp 0", rsp1_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp1_valid, rsp1_rdata} !== {1'b1, 16'h00FF}) $display("FAIL b2b_rsp got %b/%h exp 1/00ff", rsp1_valid, rsp1_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic        pend0, pend1, e0, e1;
    logic [37:0] got, exp;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; req0_rw = 1'($urandom_range(0, 1)); req0_wdata = 16'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; req1_rw = 1'($urandom_range(0, 1)); req1_wdata = 16'($urandom);
      end
      req0_valid = pend0; req1_valid = pend1;
      rst = ($urandom_range(0, 59) == 0);
      #1;
      e0  = exp_ready(0);
      e1  = exp_ready(1);
      exp = {e0, e1, m_rspv[0], m_rspv[1], m_rem != 0, !rst && m_rem != 0 && m_rw, m_rdata[0], m_rdata[1]};
      got = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, reg_rw, rsp0_rdata, rsp1_rdata};
      n_checks++; if (got !== exp) $display("FAIL rand_c%0d got %h exp %h", c, got, exp); else n_pass++;
      tick();
      if (e0) pend0 = 1'b0;
      if (e1) pend1 = 1'b0;
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_before_write();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
